// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one register stage per shift-amount bit.
// Shift/rotate modes with carry-out, valid/ready on both sides.
module barrel_shifter_pipe #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   b,
  input  logic [2:0]       aluc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH-1:0] data_q  [SHW];
  logic [WIDTH-1:0] data_d  [SHW];
  logic [SHW-1:0]   b_q     [SHW];
  logic [SHW-1:0]   b_d     [SHW];
  logic [2:0]       aluc_q  [SHW];
  logic [2:0]       aluc_d  [SHW];
  logic [SHW-1:0]   carry_q;
  logic [SHW-1:0]   carry_d;
  logic [SHW-1:0]   valid_q;
  logic [SHW-1:0]   valid_d;

  logic [WIDTH-1:0] src_data  [SHW];
  logic [SHW-1:0]   src_b     [SHW];
  logic [2:0]       src_aluc  [SHW];
  logic [SHW-1:0]   src_carry;
  logic [SHW-1:0]   src_valid;
  logic             advance;

  // Returns {carry, data} after one stage's conditional shift by sh.
  function automatic logic [WIDTH:0] step(
    input logic [WIDTH-1:0] x,
    input logic [2:0]       m,
    input logic             en,
    input logic             cin,
    input int               sh
  );
    logic [WIDTH-1:0] r;
    logic             cy;
    r  = x;
    cy = cin;
    if (en) begin
      unique case (1'b1)
        (m == 3'b000): begin
          r  = $signed(x) >>> sh;
          cy = |(x & (WIDTH'(1) << (sh - 1)));
        end
        (m == 3'b001): begin
          r  = x >> sh;
          cy = |(x & (WIDTH'(1) << (sh - 1)));
        end
        (m[2:1] == 2'b01): begin
          r  = x << sh;
          cy = |(x & (WIDTH'(1) << (WIDTH - sh)));
        end
        (m == 3'b100): begin
          r  = (x >> sh) | (x << (WIDTH - sh));
          cy = r[WIDTH-1];
        end
        (m == 3'b101): begin
          r  = (x << sh) | (x >> (WIDTH - sh));
          cy = r[0];
        end
        (m[2:1] == 2'b11): begin
          r  = x;
          cy = cin;
        end
      endcase
    end
    return {cy, r};
  endfunction

  always_comb begin
    advance      = !valid_q[SHW-1] | out_ready;
    src_data[0]  = a;
    src_b[0]     = b;
    src_aluc[0]  = aluc;
    src_carry[0] = 1'b0;
    src_valid[0] = in_valid;
    for (int k = 1; k < SHW; k++) begin
      src_data[k]  = data_q[k-1];
      src_b[k]     = b_q[k-1];
      src_aluc[k]  = aluc_q[k-1];
      src_carry[k] = carry_q[k-1];
      src_valid[k] = valid_q[k-1];
    end
    for (int k = 0; k < SHW; k++) begin
      logic [WIDTH:0] res;
      res = step(src_data[k], src_aluc[k], src_b[k][k],
                 src_carry[k], 1 << k);
      data_d[k]  = data_q[k];
      b_d[k]     = b_q[k];
      aluc_d[k]  = aluc_q[k];
      carry_d[k] = carry_q[k];
      valid_d[k] = valid_q[k];
      if (advance) begin
        data_d[k]  = res[WIDTH-1:0];
        b_d[k]     = src_b[k];
        aluc_d[k]  = src_aluc[k];
        carry_d[k] = res[WIDTH];
        valid_d[k] = src_valid[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= '0;
      valid_q <= '0;
      for (int k = 0; k < SHW; k++) begin
        data_q[k] <= '0;
        b_q[k]    <= '0;
        aluc_q[k] <= '0;
      end
    end else begin
      carry_q <= carry_d;
      valid_q <= valid_d;
      for (int k = 0; k < SHW; k++) begin
        data_q[k] <= data_d[k];
        b_q[k]    <= b_d[k];
        aluc_q[k] <= aluc_d[k];
      end
    end
  end

  assign in_ready  = advance;
  assign out_valid = valid_q[SHW-1];
  assign c         = data_q[SHW-1];
  assign carry     = carry_q[SHW-1];
  assign zero      = ~|data_q[SHW-1];

endmodule
